// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam int LINE_ADDR_LEN_DEF = 2;
  localparam int SET_ADDR_LEN_DEF  = 3;

  // Bit positions of the index and tag fields inside a byte address.
  function automatic int index_lsb(input int line_len);
    return line_len + 2;
  endfunction

  function automatic int tag_lsb(input int line_len, input int set_len);
    return line_len + set_len + 2;
  endfunction

  function automatic int tag_len(input int line_len, input int set_len);
    return 32 - tag_lsb(line_len, set_len);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: combinational reads, byte-enabled store port and line-refill port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
  parameter int TAG_ADDR_LEN  = tag_len(LINE_ADDR_LEN, SET_ADDR_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SET_ADDR_LEN-1:0]  rd_idx,
  input  logic [LINE_ADDR_LEN-1:0] rd_off,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_ADDR_LEN-1:0]  rd_tag,
  output logic [31:0]              rd_word,
  input  logic [SET_ADDR_LEN-1:0]  ln_idx,
  input  logic [LINE_ADDR_LEN-1:0] ln_off,
  output logic [31:0]              ln_word,
  input  logic                     st_en,
  input  logic [SET_ADDR_LEN-1:0]  st_idx,
  input  logic [LINE_ADDR_LEN-1:0] st_off,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_be,
  input  logic                     fl_en,
  input  logic                     fl_last,
  input  logic [SET_ADDR_LEN-1:0]  fl_idx,
  input  logic [LINE_ADDR_LEN-1:0] fl_off,
  input  logic [31:0]              fl_data,
  input  logic [TAG_ADDR_LEN-1:0]  fl_tag
);

  localparam int SETS  = 1 << SET_ADDR_LEN;
  localparam int DEPTH = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);

  logic [SETS-1:0]         valid_reg;
  logic [SETS-1:0]         dirty_reg;
  logic [TAG_ADDR_LEN-1:0] tag_mem [SETS];

  logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] rd_addr, ln_addr, st_addr, fl_addr;
  assign rd_addr = {rd_idx, rd_off};
  assign ln_addr = {ln_idx, ln_off};
  assign st_addr = {st_idx, st_off};
  assign fl_addr = {fl_idx, fl_off};

  // One storage array per byte lane so a store touches only its enabled lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (fl_en) begin
          lane_mem[fl_addr] <= fl_data[gi*8 +: 8];
        end else if (st_en && st_be[gi]) begin
          lane_mem[st_addr] <= st_data[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[rd_addr];
      assign ln_word[gi*8 +: 8] = lane_mem[ln_addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fl_en && fl_last) begin
      tag_mem[fl_idx] <= fl_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (fl_en && fl_last) begin
      valid_reg[fl_idx] <= 1'b1;
      dirty_reg[fl_idx] <= 1'b0;
    end else if (st_en) begin
      dirty_reg[st_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_dirty = dirty_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache; miss stalls the pipeline while lines move.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
  parameter int TAG_ADDR_LEN  = tag_len(LINE_ADDR_LEN, SET_ADDR_LEN)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int IDX_LSB = index_lsb(LINE_ADDR_LEN);
  localparam int TAG_LSB = tag_lsb(LINE_ADDR_LEN, SET_ADDR_LEN);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = '1;

  logic [LINE_ADDR_LEN-1:0] off;
  logic [SET_ADDR_LEN-1:0]  idx;
  logic [TAG_ADDR_LEN-1:0]  tag;
  logic                     unused_byte_bits;

  assign off = addr[IDX_LSB-1:2];
  assign idx = addr[TAG_LSB-1:IDX_LSB];
  assign tag = addr[31:TAG_LSB];
  assign unused_byte_bits = ^addr[1:0];

  state_t                   state_reg;
  logic [LINE_ADDR_LEN-1:0] cnt_reg;
  logic [LINE_ADDR_LEN-1:0] cnt_next;
  logic [SET_ADDR_LEN-1:0]  miss_idx_reg;
  logic [TAG_ADDR_LEN-1:0]  miss_tag_reg;
  logic [TAG_ADDR_LEN-1:0]  victim_tag_reg;

  logic                     line_valid, line_dirty;
  logic [TAG_ADDR_LEN-1:0]  line_tag;
  logic [31:0]              cpu_word, line_word;
  logic [SET_ADDR_LEN-1:0]  line_idx;
  logic [LINE_ADDR_LEN-1:0] line_off;
  logic                     req, hit, store_en, fill_en, fill_last;

  assign req       = rd_req | wr_req;
  assign hit       = (state_reg == IDLE) && line_valid && (line_tag == tag);
  assign miss      = req && !hit;
  assign rd_data   = (rd_req && hit) ? cpu_word : 32'h0;
  assign store_en  = !rst && wr_req && hit;
  assign fill_en   = !rst && (state_reg == FILL) && mem_ack;
  assign fill_last = (cnt_reg == LAST_BEAT);
  assign cnt_next  = cnt_reg + 1'b1;

  // The second read port pre-fetches the word the next write-back beat will carry.
  assign line_idx = (state_reg == IDLE) ? idx : miss_idx_reg;
  assign line_off = (state_reg == IDLE) ? '0 : cnt_next;

  dcache_array #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .TAG_ADDR_LEN (TAG_ADDR_LEN)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_off  (off),
    .rd_valid(line_valid),
    .rd_dirty(line_dirty),
    .rd_tag  (line_tag),
    .rd_word (cpu_word),
    .ln_idx  (line_idx),
    .ln_off  (line_off),
    .ln_word (line_word),
    .st_en   (store_en),
    .st_idx  (idx),
    .st_off  (off),
    .st_data (wr_data),
    .st_be   (wr_be),
    .fl_en   (fill_en),
    .fl_last (fill_last),
    .fl_idx  (miss_idx_reg),
    .fl_off  (cnt_reg),
    .fl_data (mem_rdata),
    .fl_tag  (miss_tag_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      mem_rd_req     <= 1'b0;
      mem_wr_req     <= 1'b0;
      mem_addr       <= 32'h0;
      mem_wdata      <= 32'h0;
      miss_idx_reg   <= '0;
      miss_tag_reg   <= '0;
      victim_tag_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req && !hit) begin
            miss_idx_reg <= idx;
            miss_tag_reg <= tag;
            cnt_reg      <= '0;
            if (line_valid && line_dirty) begin
              state_reg      <= WB;
              victim_tag_reg <= line_tag;
              mem_wr_req     <= 1'b1;
              mem_addr       <= {line_tag, idx, {LINE_ADDR_LEN{1'b0}}, 2'b00};
              mem_wdata      <= line_word;
            end else begin
              state_reg  <= FILL;
              mem_rd_req <= 1'b1;
              mem_addr   <= {tag, idx, {LINE_ADDR_LEN{1'b0}}, 2'b00};
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            if (cnt_reg == LAST_BEAT) begin
              state_reg  <= FILL;
              cnt_reg    <= '0;
              mem_wr_req <= 1'b0;
              mem_wdata  <= 32'h0;
              mem_rd_req <= 1'b1;
              mem_addr   <= {miss_tag_reg, miss_idx_reg, {LINE_ADDR_LEN{1'b0}}, 2'b00};
            end else begin
              cnt_reg   <= cnt_next;
              mem_addr  <= {victim_tag_reg, miss_idx_reg, cnt_next, 2'b00};
              mem_wdata <= line_word;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (cnt_reg == LAST_BEAT) begin
              state_reg  <= IDLE;
              cnt_reg    <= '0;
              mem_rd_req <= 1'b0;
              mem_addr   <= 32'h0;
            end else begin
              cnt_reg  <= cnt_next;
              mem_addr <= {miss_tag_reg, miss_idx_reg, cnt_next, 2'b00};
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
